// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, divider FSM states,
// packed pipeline-register layouts, and small opcode-decode helpers.
package exec_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;
  localparam int DIV_ITER = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_MUL    = 4'd11,
    ALU_DIV    = 4'd12,
    ALU_DIVU   = 4'd13,
    ALU_REM    = 4'd14,
    ALU_REMU   = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Everything the memory stage needs besides the execute result.
  typedef struct packed {
    logic [XLEN-1:0] mem_write_data;
    logic [XLEN-1:0] next_pc;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic            res_src;
    logic            mem_we;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] exec_data;
    ctrl_t           ctrl;
  } mem_stage_t;

  // Divide encodings occupy the top quarter of the opcode space.
  function automatic logic is_div_op(input alu_op_t op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic is_signed_div(input alu_op_t op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input alu_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/execute_if.sv
// Decode -> execute -> memory-access bundle; master is the decode/memory side,
// slave is the execute stage.
interface execute_if;
  import exec_pkg::*;

  logic                valid_in;
  logic [XLEN-1:0]     next_pc_in;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;
  logic [XLEN-1:0]     imm;
  logic                alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                rd_write_enable_in;
  logic [4:0]          rd_write_addr_in;
  logic                res_src_in;
  logic                mem_write_enable_in;

  logic                stall_out;
  logic [XLEN-1:0]     exec_data_out;
  logic [XLEN-1:0]     mem_write_data_out;
  logic [XLEN-1:0]     next_pc_out;
  logic                rd_write_enable_out;
  logic [4:0]          rd_write_addr_out;
  logic                res_src_out;
  logic                mem_write_enable_out;

  modport master (
    output valid_in, next_pc_in, rs1_data, rs2_data, imm, alu_src_b, alu_op,
           rd_write_enable_in, rd_write_addr_in, res_src_in, mem_write_enable_in,
    input  stall_out, exec_data_out, mem_write_data_out, next_pc_out,
           rd_write_enable_out, rd_write_addr_out, res_src_out, mem_write_enable_out
  );

  modport slave (
    input  valid_in, next_pc_in, rs1_data, rs2_data, imm, alu_src_b, alu_op,
           rd_write_enable_in, rd_write_addr_in, res_src_in, mem_write_enable_in,
    output stall_out, exec_data_out, mem_write_data_out, next_pc_out,
           rd_write_enable_out, rd_write_addr_out, res_src_out, mem_write_enable_out
  );

endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider, 32 cycles BUSY then one DONE cycle; divide-by-zero and
// signed overflow skip straight to DONE. Present only when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module div_iter
  import exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  div_state_t      state_q, state_d;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dsr_q;
  logic            neg_quo_q, neg_rem_q;

  logic            div_zero, overflow, special;
  logic [XLEN-1:0] dvd_abs, dsr_abs;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  assign special  = div_zero | overflow;

  assign dvd_abs = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign dsr_abs = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, dsr_q});
  // When ge holds the true difference is below the divisor, so 32 bits suffice.
  assign diff    = shifted[XLEN-1:0] - dsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = special ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (cnt_q == 5'(DIV_ITER - 1)) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            dsr_q <= dsr_abs;
            if (div_zero) begin
              quo_q     <= '1;
              rem_q     <= dividend;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end else if (overflow) begin
              quo_q     <= 32'h8000_0000;
              rem_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end else begin
              quo_q     <= dvd_abs;
              rem_q     <= '0;
              neg_quo_q <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
              neg_rem_q <= is_signed & dividend[XLEN-1];
            end
          end
        end
        DIV_BUSY: begin
          cnt_q <= cnt_q + 5'd1;
          quo_q <= {quo_q[XLEN-2:0], ge};
          rem_q <= ge ? diff : shifted[XLEN-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = neg_quo_q ? -quo_q : quo_q;
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule
`endif

// File: rtl/execute.sv
// Execute stage: single-cycle ALU into one pipeline register; divides (MULDIV_DIV_EN)
// stall decode via stall_out until the iterative divider reports DONE.
module execute
  import exec_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  execute_if.slave bus
);

  alu_op_t         op;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] alu_res;
  ctrl_t           ctrl_in;
  mem_stage_t      pipe_d, pipe_q;

  assign op   = alu_op_t'(bus.alu_op);
  assign op_a = bus.rs1_data;
  assign op_b = bus.alu_src_b ? bus.imm : bus.rs2_data;

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SLL:    alu_res = op_a << op_b[4:0];
      ALU_SRL:    alu_res = op_a >> op_b[4:0];
      ALU_SRA:    alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
      ALU_PASS_B: alu_res = op_b;
      ALU_MUL:    alu_res = op_a * op_b;
      // Divide encodings reach here only in the single-cycle build.
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = '0;
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    ctrl_in.mem_write_data = bus.rs2_data;
    ctrl_in.next_pc        = bus.next_pc_in;
    ctrl_in.rd_we          = bus.valid_in & bus.rd_write_enable_in;
    ctrl_in.rd_addr        = bus.rd_write_addr_in;
    ctrl_in.res_src        = bus.res_src_in;
    ctrl_in.mem_we         = bus.valid_in & bus.mem_write_enable_in;
  end

`ifdef MULDIV_DIV_EN
  logic            div_busy, div_done, div_idle, accept_div;
  logic [XLEN-1:0] div_quo, div_rem;
  ctrl_t           div_lat_ctrl;
  logic            div_lat_rem;

  assign div_idle   = ~div_busy & ~div_done;
  assign accept_div = div_idle & bus.valid_in & is_div_op(op);

  div_iter u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept_div),
    .is_signed (is_signed_div(op)),
    .dividend  (op_a),
    .divisor   (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Decode holds its inputs while stalled, but the latched copy keeps DONE
  // independent of whatever decode presents in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_lat_ctrl <= '0;
      div_lat_rem  <= 1'b0;
    end else if (accept_div) begin
      div_lat_ctrl <= ctrl_in;
      div_lat_rem  <= is_rem_op(op);
    end
  end

  assign bus.stall_out = rst_n & (accept_div | div_busy);
`else
  assign bus.stall_out = 1'b0;
`endif

  always_comb begin
    pipe_d.exec_data = alu_res;
    pipe_d.ctrl      = ctrl_in;
`ifdef MULDIV_DIV_EN
    if (div_done) begin
      pipe_d.exec_data = div_lat_rem ? div_rem : div_quo;
      pipe_d.ctrl      = div_lat_ctrl;
    end else if (accept_div || div_busy) begin
      pipe_d.ctrl.rd_we  = 1'b0;
      pipe_d.ctrl.mem_we = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign bus.exec_data_out        = pipe_q.exec_data;
  assign bus.mem_write_data_out   = pipe_q.ctrl.mem_write_data;
  assign bus.next_pc_out          = pipe_q.ctrl.next_pc;
  assign bus.rd_write_enable_out  = pipe_q.ctrl.rd_we;
  assign bus.rd_write_addr_out    = pipe_q.ctrl.rd_addr;
  assign bus.res_src_out          = pipe_q.ctrl.res_src;
  assign bus.mem_write_enable_out = pipe_q.ctrl.mem_we;

endmodule

// File: tb/tb_execute.sv
// Randomised bench for execute: a cycle-level expectation queue built from an
// arithmetic reference model, checked every cycle at the falling edge.
module tb_execute;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_if bus();

  execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic        bub;
    logic [31:0] data;
    logic [31:0] mwd;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  addr;
    logic        rs;
    logic        mwe;
  } out_t;

  typedef struct packed {
    logic stall;
    out_t o;
  } ent_t;

  ent_t exp_q[$];
  out_t prev;
  bit   prev_valid = 1'b0;
  bit   chk_en = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_AND:    r = a & b;
      ALU_OR:     r = a | b;
      ALU_XOR:    r = a ^ b;
      ALU_SLL:    r = a << b[4:0];
      ALU_SRL:    r = a >> b[4:0];
      ALU_SRA:    r = $signed(a) >>> b[4:0];
      ALU_SLT:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:   r = (a < b) ? 32'd1 : 32'd0;
      ALU_PASS_B: r = b;
      ALU_MUL:    r = a * b;
`ifdef MULDIV_DIV_EN
      ALU_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      ALU_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      ALU_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: r = (b == 0) ? a : a % b;
`endif
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic out_t bubble();
    out_t o;
    o = '0;
    o.bub = 1'b1;
    return o;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic step(input logic s, input out_t o);
    ent_t e;
    e.stall = s;
    e.o = o;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] im, input logic src, input logic we, input logic [4:0] ad,
                       input logic rs, input logic mwe, input logic [31:0] pc);
    out_t o;
    logic [31:0] b;
    int ns;
    b = src ? im : r2;
    bus.valid_in = v;
    bus.alu_op = op;
    bus.rs1_data = a;
    bus.rs2_data = r2;
    bus.imm = im;
    bus.alu_src_b = src;
    bus.rd_write_enable_in = we;
    bus.rd_write_addr_in = ad;
    bus.res_src_in = rs;
    bus.mem_write_enable_in = mwe;
    bus.next_pc_in = pc;
    o.bub = 1'b0;
    o.data = model(op, a, b);
    o.mwd = r2;
    o.pc = pc;
    o.we = we;
    o.addr = ad;
    o.rs = rs;
    o.mwe = mwe;
    ns = 0;
`ifdef MULDIV_DIV_EN
    if (v && op[3:2] == 2'b11) ns = is_special(op, a, b) ? 1 : 33;
`endif
    repeat (ns) step(1'b1, bubble());
    step(1'b0, v ? o : bubble());
  endtask

  task automatic d(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r2,
                   input logic [31:0] im, input logic src);
    issue(1'b1, op, a, r2, im, src, 1'b1, 5'd9, 1'b1, 1'b0, 32'h0000_1004);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
    chk({tag, "_data"}, bus.exec_data_out, 32'd0);
    chk({tag, "_mwd"}, bus.mem_write_data_out, 32'd0);
    chk({tag, "_pc"}, bus.next_pc_out, 32'd0);
    chk({tag, "_we"}, 32'(bus.rd_write_enable_out), 32'd0);
    chk({tag, "_addr"}, 32'(bus.rd_write_addr_out), 32'd0);
    chk({tag, "_rs"}, 32'(bus.res_src_out), 32'd0);
    chk({tag, "_mwe"}, 32'(bus.mem_write_enable_out), 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en && exp_q.size() > 0) begin
      ent_t e;
      e = exp_q.pop_front();
      chk("stall", 32'(bus.stall_out), 32'(e.stall));
      if (bus.stall_out) stall_cnt++;
      if (prev_valid) begin
        chk("rd_we", 32'(bus.rd_write_enable_out), 32'(prev.we));
        chk("mem_we", 32'(bus.mem_write_enable_out), 32'(prev.mwe));
        if (!prev.bub) begin
          chk("exec_data", bus.exec_data_out, prev.data);
          chk("mem_wdata", bus.mem_write_data_out, prev.mwd);
          chk("next_pc", bus.next_pc_out, prev.pc);
          chk("rd_addr", 32'(bus.rd_write_addr_out), 32'(prev.addr));
          chk("res_src", 32'(bus.res_src_out), 32'(prev.rs));
        end
      end
      prev = e.o;
      prev_valid = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Hand-computed values pinning the reference model.
    chk("pin_add", model(ALU_ADD, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000);
    chk("pin_sra", model(ALU_SRA, 32'h8000_0000, 32'd31), 32'hFFFF_FFFF);
    chk("pin_sltu", model(ALU_SLTU, 32'd1, 32'hFFFF_FFFF), 32'd1);
    chk("pin_slt", model(ALU_SLT, 32'hFFFF_FFFF, 32'd1), 32'd1);
    chk("pin_div", model(ALU_DIV, 32'hFFFF_FFF9, 32'd2), DIV_EN ? 32'hFFFF_FFFD : 32'd0);
    chk("pin_rem", model(ALU_REM, 32'hFFFF_FFF9, 32'd2), DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    chk("pin_divu0", model(ALU_DIVU, 32'd5, 32'd0), DIV_EN ? 32'hFFFF_FFFF : 32'd0);
    chk("pin_ovf", model(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF), DIV_EN ? 32'h8000_0000 : 32'd0);

    // Reset with a divide presented: stall must still read low.
    bus.valid_in = 1'b1;
    bus.alu_op = ALU_DIV;
    bus.rs1_data = 32'd50;
    bus.rs2_data = 32'd3;
    bus.imm = 32'd0;
    bus.alu_src_b = 1'b0;
    bus.rd_write_enable_in = 1'b1;
    bus.rd_write_addr_in = 5'd3;
    bus.res_src_in = 1'b1;
    bus.mem_write_enable_in = 1'b1;
    bus.next_pc_in = 32'h44;
    #12;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    d(ALU_ADD, 32'h7FFF_FFFF, 32'h1234_5678, 32'd1, 1'b1);
    d(ALU_SRA, 32'h8000_0000, 32'd31, 32'd0, 1'b0);
    d(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(1'b0, ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 32'h8);
    d(ALU_MUL, 32'h0001_0003, 32'h0002_0005, 32'd0, 1'b0);

    stall_cnt = 0;
    d(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
    chk("div_stall_cycles", 32'(stall_cnt), DIV_EN ? 32'd33 : 32'd0);
    d(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
    stall_cnt = 0;
    d(ALU_DIVU, 32'd5, 32'd0, 32'd0, 1'b0);
    chk("div0_stall_cycles", 32'(stall_cnt), DIV_EN ? 32'd1 : 32'd0);
    d(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    d(ALU_REMU, 32'd100, 32'd0, 32'd7, 1'b1);
    d(ALU_ADD, 32'd10, 32'd20, 32'd0, 1'b0);

    // Reset pulse in the middle of a long divide.
    bus.valid_in = 1'b1;
    bus.alu_op = ALU_DIV;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    bus.alu_src_b = 1'b0;
`ifdef MULDIV_DIV_EN
    repeat (10) step(1'b1, bubble());
`else
    issue(1'b1, ALU_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 32'h20);
`endif
    #2;
    rst_n = 1'b0;
    chk_en = 1'b0;
    prev_valid = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
    chk_en = 1'b1;
    step(1'b0, bubble());
    d(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0);
    d(ALU_SUB, 32'd3, 32'd4, 32'd0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op[3:2] == 2'b11 && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 11));
      issue($urandom_range(0, 9) != 0, op, pick(), pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom);
    end

    issue(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    issue(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port valid_in, input, 1 bit: decode presents a valid instruction this cycle.
REQ-004 SHALL have port next_pc_in, input, 32 bits: PC+4 of the instruction.
REQ-005 SHALL have ports rs1_data and rs2_data, input, 32 bits each: register operands.
REQ-006 SHALL have port imm, input, 32 bits: sign-extended immediate.
REQ-007 SHALL have port alu_src_b, input, 1 bit: 1 selects imm as operand B, 0 selects rs2_data.
REQ-008 SHALL have port alu_op, input, 4 bits: operation, encoded per exec_pkg.
REQ-009 SHALL have ports rd_write_enable_in (1 bit), rd_write_addr_in (5 bits), res_src_in (1 bit), mem_write_enable_in (1 bit), all inputs: control forwarded downstream.
REQ-010 SHALL have port stall_out, output, 1 bit: decode must hold its inputs stable while this is high.
REQ-011 SHALL have outputs exec_data_out (32 bits), mem_write_data_out (32 bits, registered rs2_data), next_pc_out (32 bits), rd_write_enable_out (1 bit), rd_write_addr_out (5 bits), res_src_out (1 bit), mem_write_enable_out (1 bit): registered inputs to the memory-access stage.

Function
REQ-012 SHALL load all outputs except stall_out from a single set of pipeline registers, one cycle after acceptance, for single-cycle ops.
REQ-013 SHALL implement ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount = B[4:0]), SLT, SLTU, PASS_B and MUL (low 32 bits of the product), with 32-bit wrap-around arithmetic.
REQ-014 SHALL load a bubble (rd_write_enable_out=0, mem_write_enable_out=0, other outputs don't-care) when valid_in=0.
REQ-015 SHALL implement DIV, DIVU, REM and REMU with an iterative FSM: IDLE -> BUSY (32 iterations, 1 bit/cycle) -> DONE -> IDLE.
REQ-016 SHALL assert stall_out combinationally in IDLE when valid_in and a divide op are present, and throughout BUSY; it SHALL be low in DONE.
REQ-017 SHALL latch operands and control on divide acceptance, load bubbles during the accept and BUSY cycles, and load the result with the latched control in DONE: result appears 34 cycles after acceptance.
REQ-018 SHALL resolve divide-by-zero (quotient 0xFFFFFFFF, remainder = dividend) and signed overflow 0x80000000/-1 (quotient 0x80000000, remainder 0) by going IDLE -> DONE directly, with a 2-cycle latency.
REQ-019 SHALL use absolute values for signed divides and negate the quotient if the operand signs differ, and the remainder if the dividend is negative.
REQ-020 SHALL accept a new instruction in the cycle after DONE; back-to-back divides incur no extra bubble beyond REQ-017.

Reset
REQ-021 SHALL, while rst_n=0, force the FSM to IDLE, the iteration counter to 0, all output registers to 0, and stall_out to 0, irrespective of clk.
REQ-022 SHALL abandon an in-progress divide on reset without producing a result.

Configuration
REQ-023 SHALL compile the divider FSM in only when MULDIV_DIV_EN is defined.
REQ-024 SHALL, without MULDIV_DIV_EN, tie stall_out to 0, contain no FSM, and execute the divide/remainder encodings in a single cycle with result 0.

Structure
REQ-025 SHALL take the alu_op encodings and the FSM state encodings from shared package exec_pkg.
REQ-026 SHALL place the iterative divider in sub-module div_iter (start/busy/done handshake, 32-bit quotient and remainder).

Verification
REQ-027 SHALL cover: ADD with rs1=0x7FFFFFFF and imm=1 (alu_src_b=1) -> exec_data_out=0x80000000 one cycle later.
REQ-028 SHALL cover: SRA with rs1=0x80000000 and rs2=31 -> 0xFFFFFFFF; SLTU with 1 vs 0xFFFFFFFF -> 1.
REQ-029 SHALL cover: DIV -7/2 -> quotient 0xFFFFFFFD after 34 cycles, with stall_out high for 33 cycles and all intermediate outputs bubbles; REM -> 0xFFFFFFFF.
REQ-030 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF after 2 cycles; DIV 0x80000000/-1 -> 0x80000000.
REQ-031 SHALL cover: rst_n pulsed low mid-BUSY -> outputs 0, stall_out 0 immediately, and the next ADD executes normally.
